// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and kernel-row selection for the convolution window feeder.
package conv_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned KROWS    = 3;
    localparam int unsigned ROW_W    = KROWS * PIX_W;
    localparam int unsigned KERNEL_W = KROWS * ROW_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2,
        EMIT2 = 2'd3
    } feed_state_t;

    // Row 0 lives in the low bits of the packed kernel.
    function automatic logic [ROW_W-1:0] kernel_row(input logic [KERNEL_W-1:0] k,
                                                    input logic [1:0]          idx);
        case (idx)
            2'd0:    return k[ROW_W-1:0];
            2'd1:    return k[2*ROW_W-1:ROW_W];
            default: return k[KERNEL_W-1:2*ROW_W];
        endcase
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage; the same column is read then overwritten on each enabled edge.
module line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = PIX_W
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers two image lines, forms each complete 3x3 window and serialises it
// as three row slices with the matching kernel rows for the MAC.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    pix_in,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [KERNEL_W-1:0] kernel_in,
    input  logic                kernel_load,
    output logic [ROW_W-1:0]    data,
    output logic [ROW_W-1:0]    weight,
    output logic [1:0]          row_idx,
    output logic                win_valid,
    output logic                win_last,
    output logic                frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned LIN_W = $clog2(IMG_H);

    feed_state_t         state;
    logic [COL_W-1:0]    col;
    logic [LIN_W-1:0]    row;
    logic [PIX_W-1:0]    lb_a_out;
    logic [PIX_W-1:0]    lb_b_out;
    logic [ROW_W-1:0]    win_r0;
    logic [ROW_W-1:0]    win_r1;
    logic [ROW_W-1:0]    win_r2;
    logic [ROW_W-1:0]    shadow_r1;
    logic [ROW_W-1:0]    shadow_r2;
    logic                shadow_last;
    logic [KERNEL_W-1:0] kernel_q;

    logic                accept;
    logic                complete;
    logic                col_end;
    logic                row_end;
    logic                at_frame_end;
    logic                load_now;
    logic [ROW_W-1:0]    next_r0;
    logic [ROW_W-1:0]    next_r1;
    logic [ROW_W-1:0]    next_r2;
    logic [KERNEL_W-1:0] kernel_eff;

    // Ready only when the window slot is free or about to free up.
    assign pix_ready    = !rst && ((state == FILL) || (state == EMIT2));
    assign accept       = pix_valid && pix_ready;
    assign col_end      = (col == COL_W'(IMG_W - 1));
    assign row_end      = (row == LIN_W'(IMG_H - 1));
    assign at_frame_end = col_end && row_end;
    assign complete     = accept && (row >= LIN_W'(2)) && (col >= COL_W'(2));
    assign load_now     = kernel_load && (state == FILL);

    // A kernel loaded on the completing edge already applies to that window.
    assign kernel_eff   = load_now ? kernel_in : kernel_q;

    // Newest column enters the top byte; bytes below are columns c-1 and c-2.
    assign next_r0 = {lb_b_out, win_r0[ROW_W-1:PIX_W]};
    assign next_r1 = {lb_a_out, win_r1[ROW_W-1:PIX_W]};
    assign next_r2 = {pix_in,   win_r2[ROW_W-1:PIX_W]};

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb_a (
        .clk  (clk),
        .en   (accept),
        .addr (col),
        .din  (pix_in),
        .dout (lb_a_out)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb_b (
        .clk  (clk),
        .en   (accept),
        .addr (col),
        .din  (lb_a_out),
        .dout (lb_b_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            col         <= '0;
            row         <= '0;
            win_r0      <= '0;
            win_r1      <= '0;
            win_r2      <= '0;
            shadow_r1   <= '0;
            shadow_r2   <= '0;
            shadow_last <= 1'b0;
            kernel_q    <= '0;
            data        <= '0;
            weight      <= '0;
            row_idx     <= 2'd0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (load_now) begin
                kernel_q <= kernel_in;
            end

            if (accept) begin
                col    <= col_end ? '0 : col + COL_W'(1);
                win_r0 <= next_r0;
                win_r1 <= next_r1;
                win_r2 <= next_r2;
                if (col_end) begin
                    row <= row_end ? '0 : row + LIN_W'(1);
                end
            end

            case (state)
                FILL, EMIT2: begin
                    win_last   <= 1'b0;
                    frame_done <= 1'b0;
                    if (complete) begin
                        state       <= EMIT0;
                        win_valid   <= 1'b1;
                        row_idx     <= 2'd0;
                        data        <= next_r0;
                        weight      <= kernel_row(kernel_eff, 2'd0);
                        shadow_r1   <= next_r1;
                        shadow_r2   <= next_r2;
                        shadow_last <= at_frame_end;
                    end else begin
                        state     <= FILL;
                        win_valid <= 1'b0;
                        row_idx   <= 2'd0;
                    end
                end
                EMIT0: begin
                    state   <= EMIT1;
                    row_idx <= 2'd1;
                    data    <= shadow_r1;
                    weight  <= kernel_row(kernel_q, 2'd1);
                end
                EMIT1: begin
                    state      <= EMIT2;
                    row_idx    <= 2'd2;
                    data       <= shadow_r2;
                    weight     <= kernel_row(kernel_q, 2'd2);
                    win_last   <= 1'b1;
                    frame_done <= shadow_last;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 4x4 image: vector table, directed corner sequences
// and a random stream checked against a window-level reference model.
module tb_conv_window_feeder;

    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;
    localparam logic [71:0] K1 = 72'h090807_060504_030201;
    localparam logic [71:0] K2 = 72'h5A5A5A_A5A5A5_C3C3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] kernel_in;
    logic        kernel_load;
    logic [23:0] data;
    logic [23:0] weight;
    logic [1:0]  row_idx;
    logic        win_valid;
    logic        win_last;
    logic        frame_done;

    conv_window_feeder #(.IMG_W(IW), .IMG_H(IH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .kernel_in   (kernel_in),
        .kernel_load (kernel_load),
        .data        (data),
        .weight      (weight),
        .row_idx     (row_idx),
        .win_valid   (win_valid),
        .win_last    (win_last),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned macc = 0;
    int unsigned wl_cnt = 0;
    int unsigned fd_cnt = 0;
    int unsigned seq_val = 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: expected output rows, each due in a specific cycle.
    typedef struct {
        logic [23:0] d;
        logic [23:0] w;
        logic [1:0]  ri;
        logic        l;
        logic        fd;
        int unsigned due;
    } exp_t;

    exp_t        exq[$];
    logic [7:0]  img [IH][IW];
    logic [71:0] mk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        bit   due;
        bit   fill;
        bit   rdy_e;
        int   r;
        int   c;
        exp_t e;
        if (rst) begin
            exq.delete();
            mk   = '0;
            macc = 0;
            chk("rst_outputs", {win_valid, pix_ready, win_last, frame_done, row_idx, data, weight}, '0);
        end else begin
            due   = (exq.size() != 0) && (exq[0].due == cyc);
            fill  = !due;
            rdy_e = fill || (exq[0].ri == 2'd2);
            chk("m_pix_ready", pix_ready, rdy_e);
            chk("m_win_valid", win_valid, due);
            if (due) begin
                e = exq.pop_front();
                chk("m_data", data, e.d);
                chk("m_weight", weight, e.w);
                chk("m_row_idx", row_idx, e.ri);
                chk("m_win_last", win_last, e.l);
                chk("m_frame_done", frame_done, e.fd);
                if (win_last) wl_cnt++;
                if (frame_done) fd_cnt++;
            end else begin
                chk("m_idle_flags", {win_last, frame_done}, 2'b00);
            end
            if (fill && kernel_load) mk = kernel_in;
            if (pix_valid && rdy_e) begin
                r = int'((macc / IW) % IH);
                c = int'(macc % IW);
                img[r][c] = pix_in;
                macc++;
                if (r >= 2 && c >= 2) begin
                    for (int k = 0; k < 3; k++) begin
                        e.d   = {img[r-2+k][c], img[r-2+k][c-1], img[r-2+k][c-2]};
                        e.w   = mk[k*24 +: 24];
                        e.ri  = 2'(k);
                        e.l   = (k == 2);
                        e.fd  = (k == 2) && (r == IH - 1) && (c == IW - 1);
                        e.due = cyc + 1 + k;
                        exq.push_back(e);
                    end
                end
            end
        end
    end

    typedef struct {
        logic        pv;
        logic [7:0]  px;
        logic        rdy;
        logic        vld;
        logic [1:0]  rix;
        logic [23:0] dat;
        logic [23:0] wgt;
        logic        lst;
        logic        fd;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t vec(input logic pv, input logic [7:0] px, input logic rdy,
                                 input logic vld, input logic [1:0] rix, input logic [23:0] dat,
                                 input logic [23:0] wgt, input logic lst, input logic fd);
        vec_t v;
        v = '{pv, px, rdy, vld, rix, dat, wgt, lst, fd};
        return v;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        pix_valid   = 1'b0;
        kernel_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        wl_cnt  = 0;
        fd_cnt  = 0;
        seq_val = 1;
    endtask

    task automatic load_kernel(input logic [71:0] k);
        kernel_in   = k;
        kernel_load = 1'b1;
        @(posedge clk);
        #1;
        kernel_load = 1'b0;
    endtask

    // Feeds n pixels (sequential raster values or random), holding a pixel until taken.
    task automatic run_stream(input int unsigned n, input bit rnd, input int unsigned pct, input bit kl);
        int unsigned got    = 0;
        int unsigned budget = 0;
        bit          took;
        pix_in    = rnd ? 8'($urandom) : 8'(seq_val);
        pix_valid = rnd ? ($urandom_range(99) < pct) : 1'b1;
        while (got < n) begin
            kernel_load = kl && ($urandom_range(19) == 0);
            if (kernel_load) kernel_in = 72'({$urandom, $urandom, $urandom});
            @(negedge clk);
            took = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (took) begin
                got++;
                seq_val = seq_val % 16 + 1;
            end
            if (took || !pix_valid) begin
                pix_in    = rnd ? 8'($urandom) : 8'(seq_val);
                pix_valid = rnd ? ($urandom_range(99) < pct) : 1'b1;
            end
            budget++;
            if (budget > n * 8 + 20) begin
                chk("stream_timeout", got, n);
                break;
            end
        end
        pix_valid   = 1'b0;
        kernel_load = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        pix_in      = '0;
        pix_valid   = 1'b0;
        kernel_in   = '0;
        kernel_load = 1'b0;
        #1;
        do_reset();

        // Kernel load followed by a cycle-exact trace of the first frame.
        for (int i = 0; i < 11; i++) tv[i] = vec(1'b1, 8'(i + 1), 1'b1, 1'b0, 2'd0, 24'h0, 24'h0, 1'b0, 1'b0);
        tv[11] = vec(1'b1, 8'd12, 1'b0, 1'b1, 2'd0, 24'h030201, 24'h030201, 1'b0, 1'b0);
        tv[12] = vec(1'b1, 8'd12, 1'b0, 1'b1, 2'd1, 24'h070605, 24'h060504, 1'b0, 1'b0);
        tv[13] = vec(1'b1, 8'd12, 1'b1, 1'b1, 2'd2, 24'h0B0A09, 24'h090807, 1'b1, 1'b0);
        tv[14] = vec(1'b1, 8'd13, 1'b0, 1'b1, 2'd0, 24'h040302, 24'h030201, 1'b0, 1'b0);
        tv[15] = vec(1'b1, 8'd13, 1'b0, 1'b1, 2'd1, 24'h080706, 24'h060504, 1'b0, 1'b0);
        tv[16] = vec(1'b1, 8'd13, 1'b1, 1'b1, 2'd2, 24'h0C0B0A, 24'h090807, 1'b1, 1'b0);
        tv[17] = vec(1'b1, 8'd14, 1'b1, 1'b0, 2'd0, 24'h0, 24'h0, 1'b0, 1'b0);
        tv[18] = vec(1'b1, 8'd15, 1'b1, 1'b0, 2'd0, 24'h0, 24'h0, 1'b0, 1'b0);
        tv[19] = vec(1'b1, 8'd16, 1'b0, 1'b1, 2'd0, 24'h070605, 24'h030201, 1'b0, 1'b0);
        tv[20] = vec(1'b1, 8'd16, 1'b0, 1'b1, 2'd1, 24'h0B0A09, 24'h060504, 1'b0, 1'b0);
        tv[21] = vec(1'b1, 8'd16, 1'b1, 1'b1, 2'd2, 24'h0F0E0D, 24'h090807, 1'b1, 1'b0);
        tv[22] = vec(1'b0, 8'd16, 1'b0, 1'b1, 2'd0, 24'h080706, 24'h030201, 1'b0, 1'b0);
        tv[23] = vec(1'b0, 8'd16, 1'b0, 1'b1, 2'd1, 24'h0C0B0A, 24'h060504, 1'b0, 1'b0);
        tv[24] = vec(1'b0, 8'd16, 1'b1, 1'b1, 2'd2, 24'h100F0E, 24'h090807, 1'b1, 1'b1);
        tv[25] = vec(1'b0, 8'd16, 1'b1, 1'b0, 2'd0, 24'h0, 24'h0, 1'b0, 1'b0);

        load_kernel(K1);
        for (int i = 0; i < 26; i++) begin
            pix_valid = tv[i].pv;
            pix_in    = tv[i].px;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), pix_ready, tv[i].rdy);
            chk($sformatf("tbl%0d_valid", i), win_valid, tv[i].vld);
            chk($sformatf("tbl%0d_last_fd", i), {win_last, frame_done}, {tv[i].lst, tv[i].fd});
            if (tv[i].vld) begin
                chk($sformatf("tbl%0d_data", i), data, tv[i].dat);
                chk($sformatf("tbl%0d_weight", i), weight, tv[i].wgt);
                chk($sformatf("tbl%0d_row_idx", i), row_idx, tv[i].rix);
            end
            @(posedge clk);
            #1;
        end
        chk("frame_accepts", macc, 16);
        chk("frame_windows", wl_cnt, 4);
        chk("frame_done_count", fd_cnt, 1);

        // kernel_load during EMIT1 must be ignored.
        do_reset();
        load_kernel(K1);
        run_stream(11, 1'b0, 100, 1'b0);
        @(posedge clk);
        #1;
        chk("kdrop_in_emit1", {win_valid, row_idx}, {1'b1, 2'd1});
        kernel_in   = K2;
        kernel_load = 1'b1;
        @(posedge clk);
        #1;
        kernel_load = 1'b0;
        run_stream(5, 1'b0, 100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("kdrop_final_weight", weight, 24'h090807);
        chk("kdrop_windows", wl_cnt, 4);

        // Reset in the middle of a window, then a clean restream.
        do_reset();
        run_stream(11, 1'b0, 100, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_in_emit1", {win_valid, row_idx}, {1'b1, 2'd1});
        rst = 1'b1;
        #1;
        chk("midrst_valid_drop", win_valid, 1'b0);
        chk("midrst_ready_drop", pix_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        wl_cnt  = 0;
        fd_cnt  = 0;
        seq_val = 1;
        run_stream(16, 1'b0, 100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_windows", wl_cnt, 4);
        chk("midrst_frame_done", fd_cnt, 1);

        // Random pixels, random valid gaps and random kernel loads over six frames.
        do_reset();
        run_stream(64, 1'b1, 70, 1'b1);
        run_stream(32, 1'b1, 100, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("rand_drained", exq.size(), 0);
        chk("rand_windows", wl_cnt, 24);
        chk("rand_frame_done", fd_cnt, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream stage of the 3-tap convolution MAC.
- Accepts a raster-order 8-bit pixel stream and buffers two previous image lines.
- Forms every fully-populated 3x3 window and serialises it as three 24-bit row slices on consecutive cycles.
- Each row slice is presented alongside the matching 24-bit kernel row, so the MAC's `data`/`weight` inputs connect directly.

Parameters:
- IMG_W, 8, pixels per image line (>=3)
- IMG_H, 8, lines per frame (>=3)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pix_in  in  8  pixel value
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  feeder can accept pix_in this cycle
- kernel_in  in  72  3x3 kernel; [23:0]=row0, [47:24]=row1, [71:48]=row2
- kernel_load  in  1  capture kernel_in
- data  out  24  window row slice; [7:0]=col c-2, [15:8]=col c-1, [23:16]=col c
- weight  out  24  kernel row matching data
- row_idx  out  2  window row currently on data/weight (0..2)
- win_valid  out  1  data/weight carry a valid window row
- win_last  out  1  row 2 of a window (MAC result boundary)
- frame_done  out  1  one-cycle pulse with win_last of the final window in a frame

Behaviour:
- Reset (async assert, sync release on clk):
  - All outputs 0; pix_ready forced 0 while rst is high.
  - FSM in FILL; col/row counters 0; kernel regs 0.
  - Line-buffer contents don't-care.
- Accept:
  - A pixel is taken when pix_valid && pix_ready.
  - Pixel position (r,c) comes from the col/row counters.
  - col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0, and the next frame starts.
- Line buffers:
  - Two IMG_W-deep buffers hold lines r-1 and r-2.
  - Each buffer is read and written at column c on every accept.
  - A 3x3 shift window advances one column per accept.
- Window completion:
  - An accept at (r,c) with r>=2 and c>=2 completes window rows r-2..r, cols c-2..c.
  - The window is snapshotted into shadow registers on that edge.
- FSM:
  - FILL: pix_ready=1.
    - An accept that completes a window -> EMIT0.
    - Otherwise stay in FILL.
  - EMIT0: win_valid=1, row_idx=0, pix_ready=0 -> EMIT1.
  - EMIT1: row_idx=1, pix_ready=0 -> EMIT2.
  - EMIT2: row_idx=2, win_last=1, pix_ready=1.
    - A concurrent accept that completes a window -> EMIT0 (back-to-back windows).
    - Otherwise -> FILL.
- Latency and throughput:
  - Accept at edge T gives row0 in cycle T+1, row1 in T+2, row2 in T+3.
  - Peak throughput is one window per 3 cycles.
- Output registering:
  - data/weight/row_idx/win_valid/win_last are registered.
  - In FILL, win_valid=0 and data/weight hold their last value.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No windows are emitted for the first two rows or the first two columns of any row; there is no padding.
- frame_done: asserted in the EMIT2 cycle of the window completed at (IMG_H-1, IMG_W-1).
- kernel_load:
  - Captured on the edge when the FSM is in FILL.
  - Dropped (no effect) in EMIT0/1/2, so all three rows of a window use one kernel.
  - The source must hold kernel_load until it sees FILL.
- pix_valid without pix_ready: no state change; the source holds pix_in.
- Reset mid-window: emission aborts immediately, win_valid drops in the same cycle, counters restart at (0,0).
- Arithmetic: none beyond counters. col is clog2(IMG_W) bits, row is clog2(IMG_H) bits.

Decomposition:
- Package conv_pkg:
  - PIX_W=8, ROW_W=24, KERNEL_W=72, KROWS=3.
  - FSM state enum {FILL, EMIT0, EMIT1, EMIT2}.
- Sub-module line_buffer (params DEPTH=IMG_W, WIDTH=8):
  - Circular register array with a shared read/write address.
  - Read-before-write on an enable.
  - Instantiated twice, chained: buffer A output feeds buffer B input.

Test Plan:
- Kernel load: IMG_W=IMG_H=4, kernel_load with kernel_in=72'h090807_060504_030201 in FILL -> weight=24'h030201 / 24'h060504 / 24'h090807 with row_idx 0/1/2 of the next window.
- First window: stream pixels 1..16 raster order (value=r*4+c+1), pix_valid held high.
  - No win_valid before pixel 11 is accepted.
  - Then data=24'h030201, 24'h070605, 24'h0B0A09 on cycles T+1..T+3, with win_last on the third.
- Back-to-back and frame end: same stream.
  - Pixel 12 is accepted during EMIT2 of window 1; the next window's rows are 24'h040302, 24'h080706, 24'h0C0B0A.
  - Exactly 4 windows are emitted in total.
  - frame_done pulses once, with the window ending 24'h100F0E.
- Backpressure: pix_valid held high throughout.
  - pix_ready is low in EMIT0/EMIT1 and no pixel is consumed there.
  - Accept count after the full frame is 16.
- Mid-window reset: assert rst during EMIT1 of window 1.
  - win_valid=0 and pix_ready=0 immediately.
  - After release, restreaming 1..16 reproduces the first-window values exactly.
- Dropped kernel_load: pulse kernel_load with a new kernel during EMIT1 -> weights remain the old kernel for that window and all later windows.
